// File: rtl/serial_to_word_inv_if.sv
// Handshake bundle between a bit-serial producer and serial_to_word_inv.
// The master modport is the producer/consumer side; slave is the assembler itself.
interface serial_to_word_inv_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PTR_W = $clog2(WIDTH)
) ();
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             flush;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [PTR_W-1:0] fill_cnt;

  modport master (
    output bit_in, bit_valid, flush, word_ready,
    input  bit_ready, word_out, word_valid, fill_cnt
  );

  modport slave (
    input  bit_in, bit_valid, flush, word_ready,
    output bit_ready, word_out, word_valid, fill_cnt
  );
endinterface

// File: rtl/serial_to_word_inv.sv
// Bit-serial word assembler with inverted write select: bit n of the stream lands at
// word[WIDTH-1-n], so the first bit becomes the MSB. Completed words leave via valid/ready.
module serial_to_word_inv #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PTR_W = $clog2(WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serial_to_word_inv_if.slave  io_bus
);

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e           r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [WIDTH-1:0] r_word, w_word_nxt;
  logic             w_bit_ready;
  logic             w_accept;
  logic             w_last;
  logic [PTR_W-1:0] w_idx;

  assign w_bit_ready = !io_bus.flush && ((r_state != StFull) || io_bus.word_ready);
  assign w_accept    = io_bus.bit_valid && w_bit_ready;
  assign w_last      = (r_ptr == PTR_W'(WIDTH - 1));
  // WIDTH is a power of two, so ~ptr == WIDTH-1-ptr.
  assign w_idx       = ~r_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_word  <= w_word_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_word_nxt  = r_word;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = StFill;
          w_ptr_nxt   = PTR_W'(1);
          w_word_nxt  = {io_bus.bit_in, {(WIDTH-1){1'b0}}};
        end
      end
      StFill: begin
        if (io_bus.flush) begin
          w_state_nxt = StIdle;
          w_ptr_nxt   = '0;
        end else if (w_accept) begin
          w_word_nxt[w_idx] = io_bus.bit_in;
          // Pointer wraps to 0 on the last bit, which is also the FULL fill count.
          w_ptr_nxt         = r_ptr + 1'b1;
          if (w_last) w_state_nxt = StFull;
        end
      end
      StFull: begin
        if (io_bus.word_ready) begin
          if (w_accept) begin
            w_state_nxt = StFill;
            w_ptr_nxt   = PTR_W'(1);
            w_word_nxt  = {io_bus.bit_in, {(WIDTH-1){1'b0}}};
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    io_bus.bit_ready  = w_bit_ready;
    io_bus.word_out   = r_word;
    io_bus.word_valid = (r_state == StFull);
    io_bus.fill_cnt   = r_ptr;
  end

endmodule

// File: tb/tb_serial_to_word_inv.sv
// Self-checking bench for serial_to_word_inv: directed scenarios plus a randomized run
// against a queue-based model of collected bits and a pending-word flag.
module tb_serial_to_word_inv;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_to_word_inv_if #(.WIDTH(W)) bus ();

  serial_to_word_inv #(.WIDTH(W)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bits held so far, whether a completed word awaits the consumer.
  bit           m_bits[$];
  logic         m_full;
  logic [W-1:0] m_word;
  bit           m_last[W];
  int           m_drained;

  function automatic void model_reset();
    m_bits.delete();
    m_full = 1'b0;
    m_word = '0;
  endfunction

  function automatic logic model_ready(logic f, logic wr);
    return !f && (!m_full || wr);
  endfunction

  function automatic void model_edge(logic b, logic v, logic f, logic wr);
    logic rdy;
    rdy = model_ready(f, wr);
    if (m_full && wr) begin
      m_full = 1'b0;
      m_drained++;
    end
    if (f) m_bits.delete();
    if (v && rdy) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          m_word[W-1-i] = m_bits[i];
          m_last[i]     = m_bits[i];
        end
        m_full = 1'b1;
        m_bits.delete();
      end
    end
  endfunction

  task automatic drive(input logic b, input logic v, input logic f, input logic wr);
    bus.bit_in     = b;
    bus.bit_valid  = v;
    bus.flush      = f;
    bus.word_ready = wr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(bus.bit_in, bus.bit_valid, bus.flush, bus.word_ready);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    n_cmp++;
    if (bus.word_valid !== 1'b0 || bus.fill_cnt !== '0 || bus.word_out !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b fill=%0d word=%h required 0/0/0000",
               bus.word_valid, bus.fill_cnt, bus.word_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.bit_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: bit_ready=%b required 1", bus.bit_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    w = 16'hA5C3;
    for (int i = 0; i < W; i++) begin
      drive(w[W-1-i], 1'b1, 1'b0, 1'b1);
      tick();
      n_cmp++;
      if (int'(bus.fill_cnt) !== m_bits.size() || bus.word_valid !== m_full) begin
        n_err++;
        $display("FAIL single_fill bit %0d: fill=%0d valid=%b required %0d/%b",
                 i, bus.fill_cnt, bus.word_valid, m_bits.size(), m_full);
      end
    end
    n_cmp++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 16'hA5C3) begin
      n_err++;
      $display("FAIL single_word: valid=%b word=%h required 1/a5c3", bus.word_valid, bus.word_out);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.word_valid !== 1'b0 || bus.word_out !== 16'hA5C3) begin
      n_err++;
      $display("FAIL single_drain: valid=%b word=%h required 0/a5c3", bus.word_valid, bus.word_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[2];
    words[0] = 16'h0001;
    words[1] = 16'h8000;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < W; i++) begin
        drive(words[k][W-1-i], 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.bit_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready word %0d bit %0d: bit_ready=%b required 1", k, i, bus.bit_ready);
        end
        tick();
        n_cmp++;
        if (int'(bus.fill_cnt) !== m_bits.size() || bus.word_valid !== m_full) begin
          n_err++;
          $display("FAIL b2b_state word %0d bit %0d: fill=%0d valid=%b required %0d/%b",
                   k, i, bus.fill_cnt, bus.word_valid, m_bits.size(), m_full);
        end
      end
      n_cmp++;
      if (bus.word_valid !== 1'b1 || bus.word_out !== words[k]) begin
        n_err++;
        $display("FAIL b2b_word %0d: valid=%b word=%h required 1/%h",
                 k, bus.word_valid, bus.word_out, words[k]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < W; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (bus.bit_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_ready cycle %0d: bit_ready=%b required 0", c, bus.bit_ready);
      end
      tick();
      n_cmp++;
      if (bus.word_valid !== 1'b1 || bus.word_out !== 16'hFFFF || bus.fill_cnt !== '0) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: valid=%b word=%h fill=%0d required 1/ffff/0",
                 c, bus.word_valid, bus.word_out, bus.fill_cnt);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (bus.bit_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: bit_ready=%b required 1", bus.bit_ready);
    end
    tick();
    n_cmp++;
    if (bus.word_valid !== 1'b0 || bus.fill_cnt !== 4'd1 || bus.word_out !== 16'h8000) begin
      n_err++;
      $display("FAIL bp_release: valid=%b fill=%0d word=%h required 0/1/8000",
               bus.word_valid, bus.fill_cnt, bus.word_out);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if (bus.fill_cnt !== '0) begin
      n_err++;
      $display("FAIL bp_flush: fill=%0d required 0", bus.fill_cnt);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] w;
    w = 16'h1234;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
    end
    n_cmp++;
    if (bus.fill_cnt !== 4'd7) begin
      n_err++;
      $display("FAIL flush_pre: fill=%0d required 7", bus.fill_cnt);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (bus.bit_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready: bit_ready=%b required 0", bus.bit_ready);
    end
    tick();
    n_cmp++;
    if (bus.fill_cnt !== '0 || bus.word_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_clear: fill=%0d valid=%b required 0/0", bus.fill_cnt, bus.word_valid);
    end
    for (int i = 0; i < W; i++) begin
      drive(w[W-1-i], 1'b1, 1'b0, 1'b1);
      tick();
    end
    n_cmp++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 16'h1234) begin
      n_err++;
      $display("FAIL flush_word: valid=%b word=%h required 1/1234", bus.word_valid, bus.word_out);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.fill_cnt !== 4'd10 || bus.word_out !== 16'hFFC0) begin
      n_err++;
      $display("FAIL areset_pre: fill=%0d word=%h required 10/ffc0", bus.fill_cnt, bus.word_out);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (bus.fill_cnt !== '0 || bus.word_out !== '0 || bus.word_valid !== 1'b0) begin
      n_err++;
      $display("FAIL areset_mid: fill=%0d word=%h valid=%b required 0/0000/0",
               bus.fill_cnt, bus.word_out, bus.word_valid);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.word_valid !== 1'b1) begin
      n_err++;
      $display("FAIL areset_full_pre: valid=%b required 1", bus.word_valid);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (bus.fill_cnt !== '0 || bus.word_out !== '0 || bus.word_valid !== 1'b0) begin
      n_err++;
      $display("FAIL areset_full: fill=%0d word=%h valid=%b required 0/0000/0",
               bus.fill_cnt, bus.word_out, bus.word_valid);
    end
    #1 rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic b, v, f, wr, sel_ok;
    m_drained = 0;
    for (int c = 0; c < 3000 && m_drained < 20; c++) begin
      b  = 1'($urandom);
      v  = ($urandom % 4) != 0;
      f  = ($urandom % 40) == 0;
      wr = ($urandom % 3) != 0;
      drive(b, v, f, wr);
      n_cmp++;
      if (bus.bit_ready !== model_ready(f, wr)) begin
        n_err++;
        $display("FAIL rand_ready cycle %0d: bit_ready=%b required %b",
                 c, bus.bit_ready, model_ready(f, wr));
      end
      tick();
      n_cmp++;
      if (int'(bus.fill_cnt) !== m_bits.size() || bus.word_valid !== m_full) begin
        n_err++;
        $display("FAIL rand_state cycle %0d: fill=%0d valid=%b required %0d/%b",
                 c, bus.fill_cnt, bus.word_valid, m_bits.size(), m_full);
      end
      if (m_full) begin
        n_cmp++;
        if (bus.word_out !== m_word) begin
          n_err++;
          $display("FAIL rand_word cycle %0d: word=%h required %h", c, bus.word_out, m_word);
        end
        sel_ok = 1'b1;
        for (int s = 0; s < W; s++) begin
          if (bus.word_out[W-1-s] !== m_last[s]) sel_ok = 1'b0;
        end
        n_cmp++;
        if (!sel_ok) begin
          n_err++;
          $display("FAIL rand_select cycle %0d: word=%h does not return serial order", c,
                   bus.word_out);
        end
      end
    end
    n_cmp++;
    if (m_drained < 20) begin
      n_err++;
      $display("FAIL rand_progress: drained %0d words required 20", m_drained);
    end
  endtask

  initial begin
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b0;
    m_drained      = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
